// File: rtl/v_mask_cmp.sv
// v_mask_cmp: element-wise vector integer compare that packs one result
// bit per element into 64-bit mask words for the vector register file.
//   clk, rst            clock, async active-high reset
//   in_valid/start/end  beat handshake and instruction framing
//   in_sew/opSel/addr   element width, compare op, mask base address
//   in_vec0/in_vec1     operand A (vs2) and operand B (vs1/scalar)
//   out_vec/addr/valid  completed mask word, byte address, strobe
module v_mask_cmp #(
  parameter int REQ_DATA_WIDTH  = 64,
  parameter int RESP_DATA_WIDTH = 64,
  parameter int REQ_ADDR_WIDTH  = 32,
  parameter int SEW_WIDTH       = 2,
  parameter int OPSEL_WIDTH     = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_start,
  input  logic                       in_end,
  input  logic [SEW_WIDTH-1:0]       in_sew,
  input  logic [OPSEL_WIDTH-1:0]     in_opSel,
  input  logic [REQ_ADDR_WIDTH-1:0]  in_addr,
  input  logic [REQ_DATA_WIDTH-1:0]  in_vec0,
  input  logic [REQ_DATA_WIDTH-1:0]  in_vec1,
  output logic [RESP_DATA_WIDTH-1:0] out_vec,
  output logic [REQ_ADDR_WIDTH-1:0]  out_addr,
  output logic                       out_valid
);

  localparam int RW = RESP_DATA_WIDTH;

  logic                      s0_valid;
  logic                      s0_start;
  logic                      s0_end;
  logic [REQ_DATA_WIDTH-1:0] s0_a;
  logic [REQ_DATA_WIDTH-1:0] s0_b;

  logic [SEW_WIDTH-1:0]      sew_q;
  logic [OPSEL_WIDTH-1:0]    op_q;
  logic [REQ_ADDR_WIDTH-1:0] addr_q;

  logic [RW-1:0]             acc;
  logic [6:0]                ptr;
  logic [REQ_ADDR_WIDTH-1:0] word_addr;

  function automatic logic op_eval(
    input logic                   eq,
    input logic                   ltu,
    input logic                   lts,
    input logic [OPSEL_WIDTH-1:0] op
  );
    logic r;
    case (op)
      3'd0:    r = eq;
      3'd1:    r = !eq;
      3'd2:    r = ltu;
      3'd3:    r = lts;
      3'd4:    r = ltu | eq;
      3'd5:    r = lts | eq;
      3'd6:    r = !(ltu | eq);
      default: r = !(lts | eq);
    endcase
    return r;
  endfunction

  logic [7:0] r8;
  logic [3:0] r16;
  logic [1:0] r32;
  logic       r64;

  always_comb begin
    r8  = '0;
    r16 = '0;
    r32 = '0;
    for (int i = 0; i < 8; i++) begin
      r8[i] = op_eval(s0_a[i*8 +: 8] == s0_b[i*8 +: 8],
                      s0_a[i*8 +: 8] <  s0_b[i*8 +: 8],
                      $signed(s0_a[i*8 +: 8]) < $signed(s0_b[i*8 +: 8]),
                      op_q);
    end
    for (int i = 0; i < 4; i++) begin
      r16[i] = op_eval(s0_a[i*16 +: 16] == s0_b[i*16 +: 16],
                       s0_a[i*16 +: 16] <  s0_b[i*16 +: 16],
                       $signed(s0_a[i*16 +: 16]) < $signed(s0_b[i*16 +: 16]),
                       op_q);
    end
    for (int i = 0; i < 2; i++) begin
      r32[i] = op_eval(s0_a[i*32 +: 32] == s0_b[i*32 +: 32],
                       s0_a[i*32 +: 32] <  s0_b[i*32 +: 32],
                       $signed(s0_a[i*32 +: 32]) < $signed(s0_b[i*32 +: 32]),
                       op_q);
    end
    r64 = op_eval(s0_a == s0_b,
                  s0_a <  s0_b,
                  $signed(s0_a) < $signed(s0_b),
                  op_q);
  end

  logic [7:0]                res;
  logic [6:0]                n_elem;
  logic [RW-1:0]             base_acc;
  logic [6:0]                base_ptr;
  logic [REQ_ADDR_WIDTH-1:0] base_addr;
  logic [RW-1:0]             merged;
  logic [6:0]                new_ptr;
  logic [RW-1:0]             keep;
  logic                      emit;

  always_comb begin
    case (sew_q)
      2'd0:    res = r8;
      2'd1:    res = {4'b0, r16};
      2'd2:    res = {6'b0, r32};
      default: res = {7'b0, r64};
    endcase
    n_elem = 7'd8 >> sew_q;
    // A start beat merges into a fresh word, dropping any partial one.
    base_acc  = s0_start ? '0 : acc;
    base_ptr  = s0_start ? 7'd0 : ptr;
    base_addr = s0_start ? addr_q : word_addr;
    merged    = base_acc | ({{(RW-8){1'b0}}, res} << base_ptr);
    new_ptr   = base_ptr + n_elem;
    keep      = new_ptr[6] ? '1
                           : ({{(RW-1){1'b0}}, 1'b1} << new_ptr[5:0]) - 1'b1;
    emit      = new_ptr[6] || s0_end;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_start <= 1'b0;
      s0_end   <= 1'b0;
      s0_a     <= '0;
      s0_b     <= '0;
      sew_q    <= '0;
      op_q     <= '0;
      addr_q   <= '0;
    end else begin
      s0_valid <= in_valid;
      if (in_valid) begin
        s0_start <= in_start;
        s0_end   <= in_end;
        s0_a     <= in_vec0;
        s0_b     <= in_vec1;
        if (in_start) begin
          sew_q  <= in_sew;
          op_q   <= in_opSel;
          addr_q <= in_addr;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      ptr       <= '0;
      word_addr <= '0;
      out_vec   <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= s0_valid && emit;
      if (s0_valid) begin
        if (emit) begin
          out_vec   <= merged & keep;
          out_addr  <= base_addr;
          acc       <= '0;
          ptr       <= '0;
          word_addr <= base_addr + REQ_ADDR_WIDTH'(8);
        end else begin
          acc       <= merged;
          ptr       <= new_ptr;
          word_addr <= base_addr;
        end
      end
    end
  end

endmodule
